// File: rtl/ula_driver_pkg.sv
// ula_driver_pkg: shared widths and opcode encoding for the ula request/response slice
package ula_driver_pkg;
  localparam int ULA_BITS = 8;
  localparam int ULA_OP = 8;
  localparam int ULA_TAG_W = 4;
  localparam int ULA_RSP_DEPTH = 2;
  typedef enum logic [7:0] {
    OP_NOT    = 8'd0,
    OP_ADD    = 8'd1,
    OP_SUB    = 8'd2,
    OP_AND    = 8'd3,
    OP_OR     = 8'd4,
    OP_XOR    = 8'd5,
    OP_PASS_A = 8'd6
  } ula_op_e;
endpackage

// File: rtl/ula.sv
// ula: combinational ALU; opcode 0 inverts operand B
module ula
  import ula_driver_pkg::*;
#(
  parameter int BITS = ULA_BITS,
  parameter int OP = ULA_OP
) (
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  input  logic [OP-1:0]   op_in,
  output logic [BITS-1:0] result_out
);
  always_comb begin
    result_out = '0;
    case (op_in)
      OP_NOT:    result_out = ~b_in;
      OP_ADD:    result_out = a_in + b_in;
      OP_SUB:    result_out = a_in - b_in;
      OP_AND:    result_out = a_in & b_in;
      OP_OR:     result_out = a_in | b_in;
      OP_XOR:    result_out = a_in ^ b_in;
      OP_PASS_A: result_out = a_in;
      default:   result_out = '0;
    endcase
  end
endmodule

// File: rtl/ula_rsp_fifo.sv
// ula_rsp_fifo: 2-entry response FIFO; caller guarantees no push when full without a pop
module ula_rsp_fifo #(
  parameter int W = 13
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         push_in,
  input  logic         pop_in,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic [1:0]   count_out
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push_in) mem_d[wr_q] = data_in;
    wr_d = wr_q ^ push_in;
    rd_d = rd_q ^ pop_in;
    count_d = count_q + {1'b0, push_in} - {1'b0, pop_in};
    data_out = mem_q[rd_q];
    count_out = count_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/ula_driver.sv
// ula_driver: valid/ready front-end that stages ALU requests and queues tagged results
module ula_driver
  import ula_driver_pkg::*;
#(
  parameter int BITS = ULA_BITS,
  parameter int OP = ULA_OP,
  parameter int TAG_W = ULA_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [OP-1:0]    req_op_in,
  input  logic [BITS-1:0]  req_a_in,
  input  logic [BITS-1:0]  req_b_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [BITS-1:0]  rsp_result_out,
  output logic             rsp_zero_out,
  output logic [TAG_W-1:0] rsp_tag_out
);
  localparam int RW = BITS + 1 + TAG_W;
  logic init_q, init_d, stage_valid_q, stage_valid_d;
  logic [OP-1:0] stage_op_q, stage_op_d;
  logic [BITS-1:0] stage_a_q, stage_a_d, stage_b_q, stage_b_d, ula_result;
  logic [TAG_W-1:0] stage_tag_q, stage_tag_d, tag_q, tag_d;
  logic [1:0] fifo_count, in_flight;
  logic [RW-1:0] fifo_head;
  logic accept, pop, move;
  ula #(.BITS(BITS), .OP(OP)) u_ula (
    .a_in(stage_a_q),
    .b_in(stage_b_q),
    .op_in(stage_op_q),
    .result_out(ula_result)
  );
  ula_rsp_fifo #(.W(RW)) u_fifo (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .push_in(move),
    .pop_in(pop),
    .data_in({ula_result, ula_result == '0, stage_tag_q}),
    .data_out(fifo_head),
    .count_out(fifo_count)
  );
  // ready depends only on registered state, so no comb path from either valid/ready input
  always_comb begin
    in_flight = fifo_count + {1'b0, stage_valid_q};
    req_ready_out = init_q && in_flight != 2'd3;
    rsp_valid_out = fifo_count != '0;
    pop = rsp_valid_out && rsp_ready_in;
    accept = req_valid_in && req_ready_out;
    move = stage_valid_q && (fifo_count < 2'(ULA_RSP_DEPTH) || pop);
    init_d = 1'b1;
    stage_valid_d = accept || (stage_valid_q && !move);
    stage_op_d = accept ? req_op_in : stage_op_q;
    stage_a_d = accept ? req_a_in : stage_a_q;
    stage_b_d = accept ? req_b_in : stage_b_q;
    stage_tag_d = accept ? tag_q : stage_tag_q;
    tag_d = accept ? tag_q + 1'b1 : tag_q;
    {rsp_result_out, rsp_zero_out, rsp_tag_out} = rsp_valid_out ? fifo_head : '0;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      init_q <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_op_q <= '0;
      stage_a_q <= '0;
      stage_b_q <= '0;
      stage_tag_q <= '0;
      tag_q <= '0;
    end else begin
      init_q <= init_d;
      stage_valid_q <= stage_valid_d;
      stage_op_q <= stage_op_d;
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      stage_tag_q <= stage_tag_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_ula_driver.sv
// tb_ula_driver: directed self-checking bench for ula_driver
module tb_ula_driver;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_zero;
  logic [7:0] req_op = 8'h00, req_a = 8'h00, req_b = 8'h00, rsp_result;
  logic [3:0] rsp_tag;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ula_driver dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_op_in(req_op), .req_a_in(req_a), .req_b_in(req_b),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_result_out(rsp_result), .rsp_zero_out(rsp_zero), .rsp_tag_out(rsp_tag)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rsp(input string tag, input logic [7:0] res, input logic z, input logic [3:0] t);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_result"}, rsp_result, res);
    chk({tag, "_zero"}, rsp_zero, z);
    chk({tag, "_tag"}, rsp_tag, t);
  endtask
  task automatic do_reset();
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask
  initial begin
    logic [7:0] nb;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_tag", rsp_tag, 0);
    step();
    rst_n = 1'b1;
    chk("init_ready_lo", req_ready, 0);
    step();
    chk("init_ready_hi", req_ready, 1);
    // not: result = ~b, one-cycle latency
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 8'h00; req_a = 8'h12; req_b = 8'h0F;
    step();
    req_valid = 1'b0;
    chk("not_lat_valid", rsp_valid, 0);
    step();
    rsp("not", 8'hF0, 1'b0, 4'd0);
    step();
    chk("not_popped", rsp_valid, 0);
    // zero flag
    do_reset();
    req_valid = 1'b1; req_b = 8'hFF;
    step();
    req_b = 8'h00;
    step();
    req_valid = 1'b0;
    rsp("zero1", 8'h00, 1'b1, 4'd0);
    step();
    rsp("zero2", 8'hFF, 1'b0, 4'd1);
    step();
    chk("zero_empty", rsp_valid, 0);
    // backpressure
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_b = 8'h01;
    step();
    req_b = 8'h02;
    step();
    req_b = 8'h03;
    step();
    chk("bp_ready_lo", req_ready, 0);
    req_b = 8'h04;
    step();
    step();
    chk("bp_ready_hold", req_ready, 0);
    rsp("bp_hold", 8'hFE, 1'b0, 4'd0);
    rsp_ready = 1'b1;
    step();
    chk("bp_ready_hi", req_ready, 1);
    rsp("bp1", 8'hFD, 1'b0, 4'd1);
    step();
    req_valid = 1'b0;
    rsp("bp2", 8'hFC, 1'b0, 4'd2);
    step();
    rsp("bp3", 8'hFB, 1'b0, 4'd3);
    step();
    chk("bp_empty", rsp_valid, 0);
    // stream: one response per cycle, tags wrap at 16
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 8'h00;
    for (int i = 0; i < 256; i++) begin
      req_b = 8'(i);
      chk("str_ready", req_ready, 1);
      step();
      if (i > 0) begin
        nb = ~8'(i - 1);
        rsp("str", nb, nb == 8'h00, 4'(i - 1));
      end
    end
    req_valid = 1'b0;
    step();
    rsp("str_last", 8'h00, 1'b1, 4'd15);
    step();
    chk("str_empty", rsp_valid, 0);
    // reset with two requests in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_b = 8'h10;
    step();
    req_b = 8'h20;
    step();
    req_valid = 1'b0;
    chk("mid_valid_pre", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_result", rsp_result, 0);
    step();
    rst_n = 1'b1;
    chk("mid_rel_ready_lo", req_ready, 0);
    step();
    chk("mid_rel_ready_hi", req_ready, 1);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_b = 8'h55;
    step();
    req_valid = 1'b0;
    step();
    rsp("mid_after", 8'hAA, 1'b0, 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
